// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one byte-serial UART transmitter among four byte
// producers. It generates the baud tick, grants requesters round-robin,
// launches one frame per grant with a start/busy handshake, and holds an
// inter-frame gap of GAP_BITS baud ticks after each frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for any req; grants one requester per edge
// S_WAIT    | tx_start issued, waiting for serializer busy (with timeout)
// S_SEND    | serializer busy with the frame; done pulses when busy drops
// S_GAP     | counting baud ticks of idle line before the next grant
module uart_tx_sched #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int GAP_BITS = 1,
  parameter int BUSY_TMO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic [7:0] data_3,
  input  logic [7:0] data_4,
  output logic [3:0] ack,
  output logic [3:0] done,
  output logic       err,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       baud_tick
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TW  = (BUSY_TMO > 2) ? $clog2(BUSY_TMO) : 1;
  localparam int GW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [BW-1:0] baud_cnt_q;
  logic        baud_tick_q;
  logic [1:0]  last_q, last_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic [7:0]  data_q, data_d;

  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        hit;
  logic [7:0]  sel_data;

  // Free-running baud divider; never realigned to frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q  <= '0;
      baud_tick_q <= 1'b0;
    end else begin
      baud_tick_q <= (baud_cnt_q == BW'(DIV - 1));
      if (baud_cnt_q == BW'(DIV - 1)) baud_cnt_q <= '0;
      else                            baud_cnt_q <= baud_cnt_q + BW'(1);
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick = last_q;
    hit  = 1'b0;
    cand = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!hit && req[cand]) begin
        pick = cand;
        hit  = 1'b1;
      end
    end
  end

  // Byte of the requester selected by the arbiter.
  always_comb begin
    case (pick)
      2'd1:    sel_data = data_2;
      2'd2:    sel_data = data_3;
      2'd3:    sel_data = data_4;
      default: sel_data = data_1;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    ack_d   = 4'b0000;
    done_d  = 4'b0000;
    err_d   = 1'b0;
    start_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          ack_d   = 4'b0001 << pick;
          start_d = 1'b1;
          data_d  = sel_data;
          last_d  = pick;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_busy) begin
          state_d = S_SEND;
        end else if (tmo_q == TW'(BUSY_TMO - 1)) begin
          // Busy never seen high in time (or dropped before we saw it).
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          done_d  = 4'b0001 << last_q;
          gap_d   = '0;
          state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (baud_tick_q) begin
          if (gap_q == GW'(GAP_BITS - 1)) state_d = S_IDLE;
          else                            gap_d   = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, bookkeeping and output registers; reset restores req[0] priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      tmo_q   <= '0;
      gap_q   <= '0;
      ack_q   <= 4'b0000;
      done_q  <= 4'b0000;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign tx_start  = start_q;
  assign tx_data   = data_q;
  assign baud_tick = baud_tick_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: byte batches are loaded into per-requester
// queues, a round-robin reference computes the grant order up front into a
// scoreboard, and a negedge monitor pops and compares as the DUT responds.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] data_1 = 8'h00, data_2 = 8'h00, data_3 = 8'h00, data_4 = 8'h00;
  logic       tx_busy = 1'b0;
  logic [3:0] ack, done;
  logic       err, tx_start, baud_tick;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .CLK_FREQ(1000000),
    .BAUD    (100000),
    .GAP_BITS(1),
    .BUSY_TMO(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_1   (data_1),
    .data_2   (data_2),
    .data_3   (data_3),
    .data_4   (data_4),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .baud_tick(baud_tick)
  );

  localparam int FRAME_LEN = 101;  // serializer holds busy 100 cycles
  localparam int TMO_LEN   = 15;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int cyc;
  exp_t       exp_q[$];
  logic [1:0] done_q[$];
  int         err_exp = 0;
  logic [7:0] src [4][$];
  logic [7:0] pend[4][$];
  logic [1:0] model_last = 2'd3;
  int  sermode = 0;
  int  bcnt = 0;
  int  tstart = 0;
  int  end_cyc = 0;
  bit  have_end = 1'b0;
  bit  backlog = 1'b0;
  int  tick_total = 0;
  int  ack_total = 0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int ceil10(int v);
    return ((v + 9) / 10) * 10;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor, serializer model and requester driver, all on the falling edge.
  initial begin
    exp_t e;
    logic [1:0] g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("baud_tick", baud_tick, (cyc >= 10 && cyc % 10 == 0) ? 1 : 0);
        if (baud_tick) tick_total++;
        if (tx_start || ack != 4'b0000) begin
          check("ack_start_pair", (tx_start && ack != 4'b0000) ? 1 : 0, 1);
          ack_total++;
          if (exp_q.size() == 0) begin
            check("unexpected_ack", ack, 0);
          end else begin
            e = exp_q.pop_front();
            check("ack_grant", ack, 32'd1 << e.g);
            check("tx_data", tx_data, e.d);
          end
          if (have_end) begin
            check("gap_min", (cyc >= ceil10(end_cyc) + 2) ? 1 : 0, 1);
            if (backlog) check("gap_exact", cyc, ceil10(end_cyc) + 2);
          end
          tstart   = cyc;
          have_end = 1'b0;
        end
        if (done != 4'b0000) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", done, 0);
          end else begin
            g = done_q.pop_front();
            check("done_id", done, 32'd1 << g);
            check("frame_len", cyc - tstart, FRAME_LEN);
          end
          end_cyc  = cyc;
          have_end = 1'b1;
          backlog  = (exp_q.size() != 0);
        end
        if (err) begin
          if (err_exp == 0) begin
            check("unexpected_err", err, 0);
          end else begin
            err_exp--;
            check("tmo_len", cyc - tstart, TMO_LEN);
          end
          end_cyc  = cyc;
          have_end = 1'b1;
          backlog  = (exp_q.size() != 0);
        end
        if (sermode == 0 && tx_start) begin
          tx_busy = 1'b1;
          bcnt    = 100;
        end else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) tx_busy = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++)
        if (ack[i] && src[i].size() > 0) void'(src[i].pop_front());
      for (int i = 0; i < 4; i++) req[i] = (src[i].size() != 0);
      data_1 = (src[0].size() != 0) ? src[0][0] : 8'h00;
      data_2 = (src[1].size() != 0) ? src[1][0] : 8'h00;
      data_3 = (src[2].size() != 0) ? src[2][0] : 8'h00;
      data_4 = (src[3].size() != 0) ? src[3][0] : 8'h00;
    end
  end

  // Reference: with every loaded requester holding req until its bytes are
  // gone, grants simply rotate over the non-empty queues after the last one.
  task automatic plan_batch(input bit tmo_mode);
    logic [7:0] work[4][$];
    int total = 0;
    int sel;
    bit found;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      work[i] = pend[i];
      total += pend[i].size();
    end
    repeat (total) begin
      found = 1'b0;
      sel = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && work[(int'(model_last) + k) % 4].size() != 0) begin
          found = 1'b1;
          sel = (int'(model_last) + k) % 4;
        end
      end
      e.g = 2'(sel);
      e.d = work[sel].pop_front();
      exp_q.push_back(e);
      model_last = 2'(sel);
      if (tmo_mode) err_exp++;
      else          done_q.push_back(2'(sel));
    end
    for (int i = 0; i < 4; i++) begin
      foreach (pend[i][j]) src[i].push_back(pend[i][j]);
      pend[i].delete();
    end
  endtask

  task automatic wait_batch();
    int budget = 4000;
    while ((exp_q.size() != 0 || done_q.size() != 0 || err_exp != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("batch_complete", exp_q.size() + done_q.size() + err_exp, 0);
    exp_q.delete();
    done_q.delete();
    err_exp = 0;
  endtask

  task automatic run_batch(input bit tmo_mode);
    plan_batch(tmo_mode);
    wait_batch();
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_baud_tick"}, baud_tick, 0);
  endtask

  initial begin
    int t0;
    int a0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single request with a fixed byte.
    pend[0].push_back(8'hA5);
    run_batch(1'b0);

    // All four requesting continuously, with a 1000-cycle tick count alongside.
    for (int i = 0; i < 4; i++)
      repeat (2) pend[i].push_back(8'($urandom));
    fork
      run_batch(1'b0);
      begin
        @(negedge clk);
        #2 t0 = tick_total;
        repeat (1000) @(negedge clk);
        #2 check("baud_1000", tick_total - t0, 100);
      end
    join

    // Leave last grant at 1, then requesters 0 and 1 together.
    pend[0].push_back(8'h11);
    pend[1].push_back(8'h22);
    run_batch(1'b0);
    pend[0].push_back(8'h33);
    pend[1].push_back(8'h44);
    run_batch(1'b0);

    // Serializer that never answers.
    sermode = 1;
    pend[3].push_back(8'hE7);
    run_batch(1'b1);
    sermode = 0;

    // Random batches.
    repeat (6) begin
      for (int i = 0; i < 4; i++)
        repeat ($urandom_range(0, 2)) pend[i].push_back(8'($urandom));
      run_batch(1'b0);
    end

    // Requester 2 raises and withdraws while another frame is on the line.
    a0 = ack_total;
    pend[0].push_back(8'h3C);
    plan_batch(1'b0);
    for (int b = 0; b < 500 && exp_q.size() != 0; b++) @(negedge clk);
    repeat (5) @(negedge clk);
    src[2].push_back(8'h77);
    repeat (20) @(negedge clk);
    src[2].delete();
    wait_batch();
    repeat (50) @(negedge clk);
    check("withdraw_acks", ack_total - a0, 1);

    // Reset in the middle of a frame.
    pend[1].push_back(8'h5A);
    plan_batch(1'b0);
    for (int b = 0; b < 500 && exp_q.size() != 0; b++) @(negedge clk);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    exp_q.delete();
    done_q.delete();
    err_exp = 0;
    for (int i = 0; i < 4; i++) src[i].delete();
    tx_busy    = 1'b0;
    bcnt       = 0;
    have_end   = 1'b0;
    model_last = 2'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pend[0].push_back(8'hC0);
    pend[1].push_back(8'hC1);
    pend[2].push_back(8'hC2);
    pend[3].push_back(8'hC3);
    run_batch(1'b0);

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
